// File: rtl/arb_pkg.sv
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types for the SRAM arbiter: response FSM state
//                encoding and requester identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    // Response tracking state: which port (if any) owns the read data
    // returned by the SRAM in the current cycle.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_RESP = 2'd1,
        ST_DM_RESP = 2'd2
    } arb_state_t;

    // Requester identifier, used by the round-robin pointer.
    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

    // The requester that is not the given one.
    function automatic req_id_t other_port(input req_id_t id);
        return (id == REQ_IF) ? REQ_DM : REQ_IF;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_grant.sv
// ============================================================================
//  Module      : arb_grant
//  Description : Two-port grant logic for the SRAM arbiter. Grants are
//                combinational from the requests and the arbitration state.
//                Default build: data port has priority, with a starvation
//                guard that forces the fetch port ahead after STARVE_LIMIT
//                consecutive denials.
//                Macro SRAM_ARB_RR_EN: plain round-robin on contention.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_grant
    import arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req_i,
    input  logic dm_req_i,
    output logic if_gnt_o,
    output logic dm_gnt_o
);

`ifdef SRAM_ARB_RR_EN

    // Points at the port that wins the next contention.
    req_id_t rr_ptr_q;
    logic    contend;

    // Grant decision: single requester wins outright, contention follows pointer.
    always_comb begin
        contend  = if_req_i && dm_req_i;
        if_gnt_o = 1'b0;
        dm_gnt_o = 1'b0;
        if (!rst) begin
            if (contend) begin
                if_gnt_o = (rr_ptr_q == REQ_IF);
                dm_gnt_o = (rr_ptr_q == REQ_DM);
            end else begin
                if_gnt_o = if_req_i;
                dm_gnt_o = dm_req_i;
            end
        end
    end

    // Pointer flips only when a contention was actually resolved.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= REQ_DM;
        end else if (contend) begin
            rr_ptr_q <= other_port(rr_ptr_q);
        end
    end

`else

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Consecutive cycles the fetch port has been refused, saturating at LIMIT.
    logic [CNT_W-1:0] starve_cnt_q;
    logic             force_if;

    // Grant decision: DM wins contention unless the fetch port is starving.
    always_comb begin
        force_if = (starve_cnt_q == LIMIT);
        if_gnt_o = 1'b0;
        dm_gnt_o = 1'b0;
        if (!rst) begin
            if_gnt_o = if_req_i && (!dm_req_i || force_if);
            dm_gnt_o = dm_req_i && !if_gnt_o;
        end
    end

    // Starvation counter: counts refused fetch cycles, cleared on a fetch grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else if (if_gnt_o) begin
            starve_cnt_q <= '0;
        end else if (if_req_i && (starve_cnt_q != LIMIT)) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
        end
    end

`endif

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
//  Module      : sram_arbiter
//  Description : Arbitrates a single-port synchronous SRAM between an
//                instruction-fetch read port (IF) and a data read/write
//                port (DM). One access per cycle, 1-cycle read latency,
//                back-to-back throughput. Each port keeps the last read
//                data in a hold register between responses.
//                Optional macro: SRAM_ARB_RR_EN selects round-robin
//                arbitration instead of DM priority with starvation guard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // data port
    input  logic              dm_req,
    input  logic              dm_web,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_bweb,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    // SRAM macro interface
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_bweb,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do
);

    arb_state_t        state_q;
    logic [DATA_W-1:0] if_hold_q;
    logic [DATA_W-1:0] dm_hold_q;

    arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk      (clk),
        .rst      (rst),
        .if_req_i (if_req),
        .dm_req_i (dm_req),
        .if_gnt_o (if_gnt),
        .dm_gnt_o (dm_gnt)
    );

    // SRAM drive: the granted requester owns the macro pins this cycle.
    always_comb begin
        sram_ceb  = 1'b1;
        sram_web  = 1'b1;
        sram_a    = '0;
        sram_bweb = '1;
        sram_di   = '0;
        if (!rst) begin
            if (if_gnt) begin
                sram_ceb = 1'b0;
                sram_a   = if_addr;
            end else if (dm_gnt) begin
                sram_ceb  = 1'b0;
                sram_web  = dm_web;
                sram_a    = dm_addr;
                sram_bweb = dm_bweb;
                sram_di   = dm_wdata;
            end
        end
    end

    // Response FSM and hold registers: remember who owns next cycle's sram_do
    // and keep each port's last returned word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            if_hold_q <= '0;
            dm_hold_q <= '0;
        end else begin
            case (state_q)
                ST_IF_RESP: if_hold_q <= sram_do;
                ST_DM_RESP: dm_hold_q <= sram_do;
                default:    ;
            endcase
            if (if_gnt) begin
                state_q <= ST_IF_RESP;
            end else if (dm_gnt && dm_web) begin
                state_q <= ST_DM_RESP;
            end else begin
                state_q <= ST_IDLE;
            end
        end
    end

    // A response in flight when reset hits is dropped, so rvalid and rdata
    // are masked while rst is high.
    assign if_rvalid = (state_q == ST_IF_RESP) && !rst;
    assign dm_rvalid = (state_q == ST_DM_RESP) && !rst;

    assign if_rdata = if_rvalid ? sram_do : (rst ? '0 : if_hold_q);
    assign dm_rdata = dm_rvalid ? sram_do : (rst ? '0 : dm_hold_q);

endmodule

`default_nettype wire
